upsample_nn: RTL and testbench

UPSAMPLE_NN -- requirements
Module: upsample_nn

---
 rtl/upsample_nn_if.sv | 20 ++
 rtl/ConvAcc.svh | 8 +
 rtl/upsample_nn.sv | 221 ++++++++++++++++++++++
 tb/tb_upsample_nn.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample_nn_if.sv
// sp_ram_intf: single-port SRAM connection used by the ConvAcc compute blocks.
//   cs      chip select (1 = access this cycle)
//   oe      output enable (tied high by compute blocks)
//   addr    word address
//   W_req   write request, encoded with WRITE_ENB / WRITE_DIS
//   W_data  write data
//   R_data  read data, valid the cycle after a read access
interface sp_ram_intf;
  logic        cs;
  logic        oe;
  logic [31:0] addr;
  logic        W_req;
  logic [31:0] W_data;
  logic [31:0] R_data;

  modport compute (output cs, output oe, output addr, output W_req, output W_data,
                   input R_data);
  modport memory  (input cs, input oe, input addr, input W_req, input W_data,
                   output R_data);
endinterface

// File: rtl/ConvAcc.svh
// Shared SRAM write-request encoding for the ConvAcc compute blocks.
`ifndef CONVACC_SVH
`define CONVACC_SVH

`define WRITE_ENB 1'b0
`define WRITE_DIS 1'b1

`endif

// File: rtl/upsample_nn.sv
// upsample_nn: nearest-neighbour upsampler (2x or 4x) between feature-map SRAMs.
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   start        launch pulse, honoured only in IDLE
//   finish       one-cycle run-complete strobe
//   param_intf   parameter SRAM (R at 0, C at 1, scale word at 2), read-only
//   input_intf   input feature map SRAM, pixel in R_data[7:0], read-only
//   output_intf  output feature map SRAM, write-only, W_data = {24'h0, pixel}
//   bias_intf, weight_intf  unused, held idle
//
// state      | meaning
// IDLE       | waiting for start
// LOAD_PARAM | 4-cycle fetch of R, C, scale
// READ       | one input pixel read for the current (c, y, j, x)
// WRITE      | S writes of that pixel along the current output row
// FINISH     | finish strobe, back to IDLE
`include "ConvAcc.svh"

module upsample_nn (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  output logic        finish,
  sp_ram_intf.compute param_intf,
  sp_ram_intf.compute input_intf,
  sp_ram_intf.compute output_intf,
  sp_ram_intf.compute bias_intf,
  sp_ram_intf.compute weight_intf
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_PARAM = 3'd1,
    READ       = 3'd2,
    WRITE      = 3'd3,
    FINISH     = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  ld_cnt;
  logic [5:0]  num_row;
  logic [7:0]  num_ch;
  logic [2:0]  scale;
  logic [7:0]  c_idx;
  logic [4:0]  y_idx;
  logic [4:0]  x_idx;
  logic [1:0]  j_idx;
  logic [1:0]  k_idx;
  logic [7:0]  pix;
  logic        p_cs;
  logic        i_cs;
  logic        o_cs;

  logic [31:0] r32;
  logic [31:0] s32;
  logic [31:0] rr;
  logic [31:0] sr;
  logic [31:0] in_addr;
  logic [31:0] out_addr;
  logic        x_last;
  logic        j_last;
  logic        y_last;
  logic        c_last;
  logic        k_last;
  logic        run_last;
  logic        unused_rdata;

  assign r32 = 32'(num_row);
  assign s32 = 32'(scale);
  assign rr  = r32 * r32;
  assign sr  = s32 * r32;

  assign in_addr  = 32'(c_idx) * rr + 32'(y_idx) * r32 + 32'(x_idx);
  assign out_addr = 32'(c_idx) * sr * sr
                  + (s32 * 32'(y_idx) + 32'(j_idx)) * sr
                  + s32 * 32'(x_idx) + 32'(k_idx);

  assign x_last   = (32'(x_idx) == r32 - 32'd1);
  assign j_last   = (32'(j_idx) == s32 - 32'd1);
  assign y_last   = (32'(y_idx) == r32 - 32'd1);
  assign c_last   = (32'(c_idx) == 32'(num_ch) - 32'd1);
  assign k_last   = (32'(k_idx) == s32 - 32'd1);
  assign run_last = x_last && j_last && y_last && c_last;

  // Addresses are gated by cs so every address reads 0 whenever its port is idle.
  assign param_intf.cs     = p_cs;
  assign param_intf.oe     = 1'b1;
  assign param_intf.addr   = p_cs ? {30'd0, ld_cnt} : 32'd0;
  assign param_intf.W_req  = `WRITE_DIS;
  assign param_intf.W_data = 32'd0;

  assign input_intf.cs     = i_cs;
  assign input_intf.oe     = 1'b1;
  assign input_intf.addr   = i_cs ? in_addr : 32'd0;
  assign input_intf.W_req  = `WRITE_DIS;
  assign input_intf.W_data = 32'd0;

  // First write of a pixel forwards the fresh read data; later writes replay the latch.
  assign output_intf.cs     = o_cs;
  assign output_intf.oe     = 1'b1;
  assign output_intf.addr   = o_cs ? out_addr : 32'd0;
  assign output_intf.W_req  = o_cs ? `WRITE_ENB : `WRITE_DIS;
  assign output_intf.W_data = o_cs ? {24'h0, (k_idx == 2'd0) ? input_intf.R_data[7:0] : pix}
                                   : 32'd0;

  assign bias_intf.cs       = 1'b0;
  assign bias_intf.oe       = 1'b1;
  assign bias_intf.addr     = 32'd0;
  assign bias_intf.W_req    = `WRITE_DIS;
  assign bias_intf.W_data   = 32'd0;

  assign weight_intf.cs     = 1'b0;
  assign weight_intf.oe     = 1'b1;
  assign weight_intf.addr   = 32'd0;
  assign weight_intf.W_req  = `WRITE_DIS;
  assign weight_intf.W_data = 32'd0;

  assign unused_rdata = ^{input_intf.R_data[31:8], output_intf.R_data,
                          bias_intf.R_data, weight_intf.R_data};

  // cs/finish are registered one step ahead so they line up with the state they serve.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ld_cnt  <= 2'd0;
      num_row <= 6'd0;
      num_ch  <= 8'd0;
      scale   <= 3'd0;
      c_idx   <= 8'd0;
      y_idx   <= 5'd0;
      x_idx   <= 5'd0;
      j_idx   <= 2'd0;
      k_idx   <= 2'd0;
      pix     <= 8'd0;
      p_cs    <= 1'b0;
      i_cs    <= 1'b0;
      o_cs    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          finish <= 1'b0;
          if (start) begin
            state  <= LOAD_PARAM;
            ld_cnt <= 2'd0;
            p_cs   <= 1'b1;
          end
        end
        LOAD_PARAM: begin
          ld_cnt <= ld_cnt + 2'd1;
          case (ld_cnt)
            2'd1: num_row <= param_intf.R_data[5:0];
            2'd2: begin
              num_ch <= param_intf.R_data[7:0];
              p_cs   <= 1'b0;
            end
            2'd3: begin
              scale <= (param_intf.R_data == 32'd4) ? 3'd4 : 3'd2;
              c_idx <= 8'd0;
              y_idx <= 5'd0;
              x_idx <= 5'd0;
              j_idx <= 2'd0;
              k_idx <= 2'd0;
              if (num_row == 6'd0 || num_ch == 8'd0) begin
                state  <= FINISH;
                finish <= 1'b1;
              end else begin
                state <= READ;
                i_cs  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        READ: begin
          i_cs  <= 1'b0;
          o_cs  <= 1'b1;
          k_idx <= 2'd0;
          state <= WRITE;
        end
        WRITE: begin
          if (k_idx == 2'd0) pix <= input_intf.R_data[7:0];
          if (k_last) begin
            o_cs <= 1'b0;
            if (!x_last) begin
              x_idx <= x_idx + 5'd1;
            end else begin
              x_idx <= 5'd0;
              if (!j_last) begin
                j_idx <= j_idx + 2'd1;
              end else begin
                j_idx <= 2'd0;
                if (!y_last) begin
                  y_idx <= y_idx + 5'd1;
                end else begin
                  y_idx <= 5'd0;
                  c_idx <= c_idx + 8'd1;
                end
              end
            end
            if (run_last) begin
              state  <= FINISH;
              finish <= 1'b1;
            end else begin
              state <= READ;
              i_cs  <= 1'b1;
            end
          end else begin
            k_idx <= k_idx + 2'd1;
          end
        end
        FINISH: begin
          finish <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upsample_nn.sv
// tb_upsample_nn: directed scoreboard bench for upsample_nn.
// SRAM models answer reads one cycle after cs; every output write is popped
// from an expected-write queue built from a reference traversal.
module tb_upsample_nn;

  localparam logic WEN  = 1'b0;
  localparam logic WDIS = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic finish;

  sp_ram_intf param_if ();
  sp_ram_intf input_if ();
  sp_ram_intf output_if ();
  sp_ram_intf bias_if ();
  sp_ram_intf weight_if ();

  upsample_nn dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .finish      (finish),
    .param_intf  (param_if),
    .input_intf  (input_if),
    .output_intf (output_if),
    .bias_intf   (bias_if),
    .weight_intf (weight_if)
  );

  always #5 clk = ~clk;

  logic [31:0] param_mem [0:3];
  logic [31:0] in_mem [0:1023];

  always @(posedge clk) begin
    if (param_if.cs === 1'b1) param_if.R_data <= param_mem[param_if.addr[1:0]];
    if (input_if.cs === 1'b1) input_if.R_data <= in_mem[input_if.addr[9:0]];
  end
  assign output_if.R_data = 32'd0;
  assign bias_if.R_data   = 32'd0;
  assign weight_if.R_data = 32'd0;

  int  checks = 0;
  int  errors = 0;
  int  wr_seen = 0;
  int  fin_count = 0;
  logic fin_prev = 1'b0;
  wr_t exp_q [$];

  always @(negedge clk) begin
    wr_t e;
    if (output_if.cs === 1'b1 && output_if.W_req === WEN) begin
      wr_seen++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write: got addr %0h data %0h, expected no write",
               output_if.addr, output_if.W_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        assert ({output_if.addr, output_if.W_data} === {e.addr, e.data}) else begin
          errors++;
          $error("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                 output_if.addr, output_if.W_data, e.addr, e.data);
        end
      end
    end
    if (finish === 1'b1) begin
      fin_count++;
      checks++;
      assert (fin_prev === 1'b0) else begin
        errors++;
        $error("FAIL finish_width: got finish high %0d cycles in a row, expected 1", 2);
      end
      checks++;
      assert ({param_if.cs, input_if.cs, output_if.cs} === 3'b000) else begin
        errors++;
        $error("FAIL finish_cs: got cs %b, expected 000",
               {param_if.cs, input_if.cs, output_if.cs});
      end
    end
    fin_prev = finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of run, expected the bench to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    logic [135:0] got;
    logic [135:0] want;
    got  = {param_if.cs, input_if.cs, output_if.cs, param_if.addr, input_if.addr,
            output_if.addr, param_if.W_req, input_if.W_req, output_if.W_req,
            output_if.W_data, finish};
    want = {3'b000, 96'd0, WDIS, WDIS, WDIS, 32'd0, 1'b0};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic check_unused_ports(input string tag);
    logic [139:0] got;
    logic [139:0] want;
    got  = {bias_if.cs, weight_if.cs, bias_if.addr, weight_if.addr, bias_if.W_req,
            weight_if.W_req, bias_if.W_data, weight_if.W_data, param_if.oe, input_if.oe,
            output_if.oe, bias_if.oe, weight_if.oe, 2'b00};
    want = {2'b00, 64'd0, WDIS, WDIS, 64'd0, 5'b11111, 2'b00};
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic setup(input int r, input int c, input int sw);
    int  s;
    wr_t e;
    param_mem[0] = 32'(r);
    param_mem[1] = 32'(c);
    param_mem[2] = 32'(sw);
    param_mem[3] = 32'hFFFF_FFFF;
    s = (sw == 4) ? 4 : 2;
    for (int cc = 0; cc < c; cc++)
      for (int y = 0; y < r; y++)
        for (int j = 0; j < s; j++)
          for (int x = 0; x < r; x++)
            for (int k = 0; k < s; k++) begin
              e.addr = 32'(cc * (s * r) * (s * r) + (s * y + j) * (s * r) + s * x + k);
              e.data = {24'h0, in_mem[cc * r * r + y * r + x][7:0]};
              exp_q.push_back(e);
            end
  endtask

  task automatic launch_and_wait(input string tag, input int exp_lat);
    int n;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (finish === 1'b1) seen = 1'b1;
    end
    checks++;
    assert (seen && n == exp_lat) else begin
      errors++;
      $error("FAIL %s_latency: got %0d cycles (seen=%0d), expected %0d", tag, n, seen, exp_lat);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL %s_count: got %0d writes missing, expected 0", tag, exp_q.size());
    end
  endtask

  initial begin
    int n;
    int f1;
    int f2;
    int fc0;
    int base;
    bit hit;

    for (int i = 0; i < 1024; i++) in_mem[i] = $urandom;
    for (int i = 0; i < 4; i++) param_mem[i] = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    check_unused_ports("unused_ports_reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 2x, R=2, C=1, pixels 1..4 with junk in upper bits
    in_mem[0] = 32'h5A5A_5A01;
    in_mem[1] = 32'hA5A5_A502;
    in_mem[2] = 32'hFFFF_FF03;
    in_mem[3] = 32'h1234_5604;
    setup(2, 1, 2);
    launch_and_wait("r2c1s2", 29);

    // Scale word 3 falls back to 2x
    setup(2, 1, 3);
    launch_and_wait("r2c1s3", 29);

    // 4x, R=1, C=2, sign-bit-adjacent pixels
    in_mem[0] = 32'hFFFF_FF7F;
    in_mem[1] = 32'h1234_5680;
    setup(1, 2, 4);
    launch_and_wait("r1c2s4", 45);

    // 4x, R=3, C=2, random pixels: 2*3*3*4*5 = 360 busy cycles
    for (int i = 0; i < 32; i++) in_mem[i] = $urandom;
    setup(3, 2, 4);
    launch_and_wait("r3c2s4", 365);

    // 2x, R=4, C=3: 3*4*4*2*3 = 288 busy cycles
    setup(4, 3, 2);
    launch_and_wait("r4c3s2", 293);

    // Empty runs
    setup(0, 1, 2);
    launch_and_wait("r0", 5);
    setup(2, 0, 4);
    launch_and_wait("c0", 5);

    // Reset during the 7th write of the R=2 C=1 2x run
    in_mem[0] = 32'h0000_0001;
    in_mem[1] = 32'h0000_0002;
    in_mem[2] = 32'h0000_0003;
    in_mem[3] = 32'h0000_0004;
    setup(2, 1, 2);
    base = wr_seen;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    hit = 1'b0;
    while (n < 200 && !hit) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      n++;
      if (wr_seen == base + 6 && output_if.cs === 1'b1 && output_if.W_req === WEN) hit = 1'b1;
    end
    checks++;
    assert (hit) else begin
      errors++;
      $error("FAIL abort_reach_7th: got %0d writes after %0d cycles, expected a 7th write", wr_seen - base, n);
    end
    rstn = 1'b0;
    #1;
    check_reset_outputs("abort_outputs");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_reset_outputs("abort_held");
    rstn = 1'b1;
    @(negedge clk);
    setup(2, 1, 2);
    launch_and_wait("after_abort", 29);

    // start held high across two runs
    setup(2, 1, 2);
    setup(2, 1, 2);
    fc0 = fin_count;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    f1 = 0;
    f2 = 0;
    while (n < 400 && f2 == 0) begin
      @(posedge clk);
      #1;
      n++;
      if (finish === 1'b1) begin
        if (f1 == 0) f1 = n;
        else f2 = n;
      end
    end
    start = 1'b0;
    checks++;
    assert (f1 == 29) else begin
      errors++;
      $error("FAIL held_first_latency: got %0d, expected %0d", f1, 29);
    end
    checks++;
    assert (f2 - f1 == 30) else begin
      errors++;
      $error("FAIL held_relaunch_gap: got %0d, expected %0d", f2 - f1, 30);
    end
    repeat (40) @(negedge clk);
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL held_count: got %0d writes missing, expected 0", exp_q.size());
    end
    checks++;
    assert (fin_count == fc0 + 2) else begin
      errors++;
      $error("FAIL held_runs: got %0d finishes, expected %0d", fin_count - fc0, 2);
    end
    check_reset_outputs("idle_after_runs");
    check_unused_ports("unused_ports_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
